// File: rtl/darkbus_sram_if.sv
// darkbus_sram_if: darkbus signal bundle; the consumer answers requests
// and drives DATA only while acknowledging a read.
interface darkbus_sram_if;
    logic        EN;
    logic        RE;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] ADDR;
    logic        RACK;
    logic        WACK;
    wire  [31:0] DATA;
    modport cons(input EN, RE, WE, BE, ADDR, output RACK, WACK, inout DATA);
    modport prod(output EN, RE, WE, BE, ADDR, input RACK, WACK, inout DATA);
endinterface

// File: rtl/darkbus_sram.sv
// darkbus_sram: word-addressed SRAM window on darkbus with a fixed number
// of wait states per access and a single-cycle registered acknowledge.
module darkbus_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          AW          = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input logic          CLK,
    input logic          RES,
    darkbus_sram_if.cons BUS
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    state_t        state, nxt;
    logic [3:0]    cnt;
    logic [AW-1:0] idx, acc_idx;
    logic          is_wr, acc_wr, rack, wack, hit, req;
    logic [3:0]    be_q, acc_be;
    logic [31:0]   wd_q, acc_wd, rd_q;
    logic [31:0]   mem [2**AW];
    logic          unused_addr;
    assign unused_addr = ^BUS.ADDR[1:0];
    assign hit = BUS.EN && BUS.ADDR[31:AW+2] == BASE_ADDR[31:AW+2];
    assign req = hit && (BUS.RE || BUS.WE);
    // With zero wait states IDLE hops straight to ACK, so the live request is used.
    assign acc_wr  = state == S_IDLE ? BUS.WE : is_wr;
    assign acc_idx = state == S_IDLE ? BUS.ADDR[AW+1:2] : idx;
    assign acc_be  = state == S_IDLE ? BUS.BE : be_q;
    assign acc_wd  = state == S_IDLE ? BUS.DATA : wd_q;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = !req ? S_IDLE : WAIT_CYCLES == 0 ? S_ACK : S_WAIT;
            S_WAIT:  nxt = !BUS.EN ? S_IDLE : cnt == 4'd1 ? S_ACK : S_WAIT;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state <= S_IDLE;
            cnt   <= '0;
            rack  <= 1'b0;
            wack  <= 1'b0;
            is_wr <= 1'b0;
            idx   <= '0;
            be_q  <= '0;
            wd_q  <= '0;
        end else begin
            state <= nxt;
            rack  <= nxt == S_ACK && !acc_wr;
            wack  <= nxt == S_ACK && acc_wr;
            if (state == S_IDLE && req) begin
                is_wr <= BUS.WE;
                idx   <= BUS.ADDR[AW+1:2];
                be_q  <= BUS.BE;
                wd_q  <= BUS.DATA;
                cnt   <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT && cnt > 4'd1) begin
                cnt <= cnt - 4'd1;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (nxt == S_ACK) begin
            if (acc_wr)
                for (int i = 0; i < 4; i++)
                    if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
            rd_q <= mem[acc_idx];
        end
    end
    assign BUS.RACK = rack;
    assign BUS.WACK = wack;
    assign BUS.DATA = rack ? rd_q : 32'bz;
endmodule

// File: tb/tb_darkbus_sram.sv
// tb_darkbus_sram: directed checks of three darkbus_sram instances
// (1, 3 and 0 wait states) sharing one stimulus bus selected by sel.
module tb_darkbus_sram;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic        en, re, we, drv;
    logic [3:0]  be;
    logic [31:0] addr, wd;
    logic        rack, wack, hz;
    logic [31:0] rdat;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_data [4];

    darkbus_sram_if b0();
    darkbus_sram_if b1();
    darkbus_sram_if b3();

    darkbus_sram #(.BASE_ADDR(32'h4000_0000), .AW(10), .WAIT_CYCLES(0)) u0 (.CLK(clk), .RES(rst_n), .BUS(b0));
    darkbus_sram #(.BASE_ADDR(32'h4000_0000), .AW(10), .WAIT_CYCLES(1)) u1 (.CLK(clk), .RES(rst_n), .BUS(b1));
    darkbus_sram #(.BASE_ADDR(32'h4000_0000), .AW(10), .WAIT_CYCLES(3)) u3 (.CLK(clk), .RES(rst_n), .BUS(b3));

    always #5 clk = ~clk;

    assign b0.EN = en && sel == 2'd0;
    assign b1.EN = en && sel == 2'd1;
    assign b3.EN = en && sel == 2'd3;
    assign b0.RE = re;
    assign b1.RE = re;
    assign b3.RE = re;
    assign b0.WE = we;
    assign b1.WE = we;
    assign b3.WE = we;
    assign b0.BE = be;
    assign b1.BE = be;
    assign b3.BE = be;
    assign b0.ADDR = addr;
    assign b1.ADDR = addr;
    assign b3.ADDR = addr;
    assign b0.DATA = (drv && sel == 2'd0) ? wd : 32'bz;
    assign b1.DATA = (drv && sel == 2'd1) ? wd : 32'bz;
    assign b3.DATA = (drv && sel == 2'd3) ? wd : 32'bz;

    assign rack = sel == 2'd0 ? b0.RACK : sel == 2'd1 ? b1.RACK : b3.RACK;
    assign wack = sel == 2'd0 ? b0.WACK : sel == 2'd1 ? b1.WACK : b3.WACK;
    assign rdat = sel == 2'd0 ? b0.DATA : sel == 2'd1 ? b1.DATA : b3.DATA;
    assign hz   = sel == 2'd0 ? (b0.DATA === 32'bz) : sel == 2'd1 ? (b1.DATA === 32'bz) : (b3.DATA === 32'bz);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en = 1'b0; re = 1'b0; we = 1'b0; drv = 1'b0; be = 4'h0;
    endtask

    // Issue one request at the current negedge; inputs are scrambled once latched.
    task automatic xfer(input string tag, input logic w, input logic both, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int wc, input logic [31:0] exp);
        en = 1'b1; re = !w || both; we = w; addr = a; wd = d; be = b; drv = w;
        for (int k = 1; k <= wc; k++) begin
            @(negedge clk);
            chk({tag, "_wait"}, {30'd0, rack, wack}, 32'd0);
            if (!w) chk({tag, "_wait_hz"}, {31'd0, hz}, 32'd1);
            addr = ~a; be = ~b; wd = ~d;
        end
        @(negedge clk);
        chk({tag, "_ack"}, {30'd0, rack, wack}, {30'd0, !w, w});
        if (!w) chk({tag, "_data"}, rdat, exp);
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, rack, wack}, 32'd0);
        if (!w) chk({tag, "_done_hz"}, {31'd0, hz}, 32'd1);
    endtask

    initial begin
        b2b_addr = '{32'h4000_0000, 32'h4000_0004, 32'h4000_0800, 32'h4000_0FFC};
        b2b_data = '{32'h1020_3040, 32'h1121_3141, 32'hA5A5_5A5A, 32'hFFFF_0001};
        rst_n = 1'b0; sel = 2'd1; addr = '0; wd = '0;
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", {30'd0, rack, wack}, 32'd0);
        chk("rst_hz", {31'd0, hz}, 32'd1);
        chk("rst_others", {28'd0, b0.RACK, b0.WACK, b3.RACK, b3.WACK}, 32'd0);
        rst_n = 1'b1;
        xfer("wr_beef", 1'b1, 1'b0, 32'h4000_0008, 32'hDEAD_BEEF, 4'hF, 1, 32'h0);
        xfer("rd_beef", 1'b0, 1'b0, 32'h4000_0008, 32'h0, 4'hF, 1, 32'hDEAD_BEEF);
        xfer("wr_word", 1'b1, 1'b0, 32'h4000_000C, 32'h1122_3344, 4'hF, 1, 32'h0);
        xfer("wr_lane2", 1'b1, 1'b0, 32'h4000_000C, 32'h00AA_0000, 4'h4, 1, 32'h0);
        xfer("rd_lane2", 1'b0, 1'b0, 32'h4000_000C, 32'h0, 4'h0, 1, 32'h11AA_3344);
        xfer("rd_lowbits", 1'b0, 1'b0, 32'h4000_000F, 32'h0, 4'h1, 1, 32'h11AA_3344);
        xfer("wr_be0", 1'b1, 1'b0, 32'h4000_0008, 32'h0000_0000, 4'h0, 1, 32'h0);
        xfer("rd_be0", 1'b0, 1'b0, 32'h4000_0008, 32'h0, 4'hF, 1, 32'hDEAD_BEEF);
        xfer("wr_both", 1'b1, 1'b1, 32'h4000_0010, 32'hCAFE_F00D, 4'hF, 1, 32'h0);
        xfer("rd_both", 1'b0, 1'b0, 32'h4000_0010, 32'h0, 4'hF, 1, 32'hCAFE_F00D);
        idle();
        en = 1'b1; re = 1'b1; addr = 32'h4000_1000;
        repeat (20) begin
            @(negedge clk);
            chk("miss_rd_ack", {30'd0, rack, wack}, 32'd0);
            chk("miss_rd_hz", {31'd0, hz}, 32'd1);
        end
        re = 1'b0; we = 1'b1; addr = 32'h4000_1008; wd = 32'h5555_5555; be = 4'hF; drv = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("miss_wr_ack", {30'd0, rack, wack}, 32'd0);
        end
        idle();
        @(negedge clk);
        en = 1'b1; re = 1'b1; addr = 32'h4000_0008;
        @(negedge clk);
        chk("rst_rd_wait", {30'd0, rack, wack}, 32'd0);
        @(negedge clk);
        chk("rst_rd_ack", {30'd0, rack, wack}, 32'd2);
        chk("rst_rd_data", rdat, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        chk("rst_imm_ack", {30'd0, rack, wack}, 32'd0);
        chk("rst_imm_hz", {31'd0, hz}, 32'd1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1; we = 1'b1; addr = 32'h4000_0008; wd = 32'h1234_5678; be = 4'hF; drv = 1'b1;
        @(negedge clk);
        chk("rst_wr_wait", {30'd0, rack, wack}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_imm", {30'd0, rack, wack}, 32'd0);
        idle();
        #1;
        chk("rst_wr_hz", {31'd0, hz}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_after_ack", {30'd0, rack, wack}, 32'd0);
        end
        xfer("rd_after_rst", 1'b0, 1'b0, 32'h4000_0008, 32'h0, 4'hF, 1, 32'hDEAD_BEEF);
        idle();
        @(negedge clk);
        sel = 2'd3;
        xfer("w3", 1'b1, 1'b0, 32'h4000_0020, 32'h0BAD_F00D, 4'hF, 3, 32'h0);
        en = 1'b1; re = 1'b1; we = 1'b0; drv = 1'b0; addr = 32'h4000_0020;
        @(negedge clk);
        chk("abort_wait", {30'd0, rack, wack}, 32'd0);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("abort_ack", {30'd0, rack, wack}, 32'd0);
            chk("abort_hz", {31'd0, hz}, 32'd1);
        end
        xfer("r3", 1'b0, 1'b0, 32'h4000_0020, 32'h0, 4'hF, 3, 32'h0BAD_F00D);
        idle();
        @(negedge clk);
        sel = 2'd0;
        for (int i = 0; i < 4; i++)
            xfer("b2b_wr", 1'b1, 1'b0, b2b_addr[i], b2b_data[i], 4'hF, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            xfer("b2b_rd", 1'b0, 1'b0, b2b_addr[i], 32'h0, 4'hF, 0, b2b_data[i]);
        idle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
